// File: rtl/pwrok_seq_block.sv
// PCH_PWROK / SYS_PWROK sequencer: waits for the VCCIN VR after vccin_en, times both power-good delays, latches a VR timeout fault.
// Optional: define PWROK_DEGLITCH_EN to require a 3-clock low on the synchronised VR-ready before dropping out of DLY_PCH/DLY_SYS/ON.
module pwrok_seq_block #(
    parameter int PWROK_DLY  = 10,
    parameter int SYS_DLY    = 5,
    parameter int VR_TIMEOUT = 500,
    parameter int CNT_W      = 16
) (
    input  logic       clk_100Khz,
    input  logic       reset,
    input  logic       vccin_en,
    input  logic       vr_ready_vccin,
    output logic       pch_pwrok,
    output logic       sys_pwrok,
    output logic       pwrok_fault,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VR = 3'd1,
        ST_DLY_PCH = 3'd2,
        ST_DLY_SYS = 3'd3,
        ST_ON      = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PCH_LAST = CNT_W'(PWROK_DLY - 1);
    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(VR_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_meta_q, en_sync_q, vr_meta_q, vr_sync_q;
    logic             pch_q, sys_q, fault_q;
    logic             s_en, s_vr, vr_lost_s;

    assign s_en = en_sync_q;
    assign s_vr = vr_sync_q;

    // Two-flop synchronisers for the asynchronous pad inputs
    always_ff @(posedge clk_100Khz) begin
        if (reset) begin
            en_meta_q <= 1'b0;
            en_sync_q <= 1'b0;
            vr_meta_q <= 1'b0;
            vr_sync_q <= 1'b0;
        end else begin
            en_meta_q <= vccin_en;
            en_sync_q <= en_meta_q;
            vr_meta_q <= vr_ready_vccin;
            vr_sync_q <= vr_meta_q;
        end
    end

`ifdef PWROK_DEGLITCH_EN
    logic [1:0] low_q, low_d;

    // Saturating run length of consecutive low VR-ready samples
    always_comb begin
        low_d = 2'd0;
        if (s_vr) begin
            low_d = 2'd0;
        end else if (low_q == 2'd3) begin
            low_d = 2'd3;
        end else begin
            low_d = low_q + 2'd1;
        end
    end

    // Low-run counter register
    always_ff @(posedge clk_100Khz) begin
        if (reset) begin
            low_q <= 2'd0;
        end else begin
            low_q <= low_d;
        end
    end

    // Third consecutive low sample is the one that counts as a real loss
    assign vr_lost_s = !s_vr && (low_q >= 2'd2);
`else
    assign vr_lost_s = !s_vr;
`endif

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s_en) begin
                    state_d = ST_WAIT_VR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_VR: begin
                if (!s_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (s_vr) begin
                    state_d = ST_DLY_PCH;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DLY_PCH: begin
                if (!s_en || vr_lost_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == PCH_LAST) begin
                    state_d = ST_DLY_SYS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DLY_SYS: begin
                if (!s_en || vr_lost_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SYS_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ON: begin
                cnt_d = '0;
                if (!s_en || vr_lost_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_FAULT: begin
                // A late VR does not clear the fault; only dropping the enable does
                cnt_d = '0;
                if (!s_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and output registers; outputs decode the next state so they align with seq_state
    always_ff @(posedge clk_100Khz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pch_q   <= 1'b0;
            sys_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pch_q   <= (state_d == ST_DLY_SYS) || (state_d == ST_ON);
            sys_q   <= (state_d == ST_ON);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign pch_pwrok   = pch_q;
    assign sys_pwrok   = sys_q;
    assign pwrok_fault = fault_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_pwrok_seq_block.sv
// Directed self-checking bench for pwrok_seq_block: default-parameter instance plus a minimum-delay instance.
module tb_pwrok_seq_block;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, vr = 1'b0, en2 = 1'b0, vr2 = 1'b0;
    logic       pch, sys, flt, pch2, sys2, flt2;
    logic [2:0] st, st2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pwrok_seq_block dut (
        .clk_100Khz(clk), .reset(reset), .vccin_en(en), .vr_ready_vccin(vr),
        .pch_pwrok(pch), .sys_pwrok(sys), .pwrok_fault(flt), .seq_state(st)
    );

    pwrok_seq_block #(.PWROK_DLY(1), .SYS_DLY(1), .VR_TIMEOUT(1), .CNT_W(16)) dut_min (
        .clk_100Khz(clk), .reset(reset), .vccin_en(en2), .vr_ready_vccin(vr2),
        .pch_pwrok(pch2), .sys_pwrok(sys2), .pwrok_fault(flt2), .seq_state(st2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expects the next edge to be the one that first samples vccin_en high
    task automatic check_seq(input string tag);
        logic [2:0] exp_st;
        for (int i = 0; i < 20; i++) begin
            step(1);
            exp_st = (i < 2) ? 3'd0 : (i < 3) ? 3'd1 : (i < 13) ? 3'd2 : (i < 18) ? 3'd3 : 3'd4;
            checks++;
            if (st !== exp_st || pch !== (i >= 13) || sys !== (i >= 18) || flt !== 1'b0) begin
                errors++;
                $display("FAIL %s k+%0d: got st=%0d pch=%b sys=%b flt=%b want st=%0d pch=%b sys=%b flt=0",
                         tag, i, st, pch, sys, flt, exp_st, (i >= 13), (i >= 18));
            end
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        vr = 1'b0;
        step(4);
        checks++;
        if (st !== 3'd0) begin
            errors++;
            $display("FAIL go_idle: got st=%0d want 0", st);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++;
        if ({st, pch, sys, flt} !== 6'd0 || {st2, pch2, sys2, flt2} !== 6'd0) begin
            errors++;
            $display("FAIL reset: got st=%0d pch=%b sys=%b flt=%b st2=%0d want all 0", st, pch, sys, flt, st2);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_nominal();
        go_idle();
        vr = 1'b1;
        en = 1'b1;
        check_seq("nominal");
    endtask

    task automatic test_timeout();
        logic [2:0] exp_st;
        go_idle();
        en = 1'b1;
        for (int i = 0; i < 506; i++) begin
            step(1);
            exp_st = (i < 2) ? 3'd0 : (i < 502) ? 3'd1 : 3'd5;
            if (i == 1 || i == 2 || i == 501 || i == 502 || i == 505) begin
                checks++;
                if (st !== exp_st || flt !== (i >= 502) || pch !== 1'b0 || sys !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout k+%0d: got st=%0d flt=%b pch=%b sys=%b want st=%0d flt=%b pch=0 sys=0",
                             i, st, flt, pch, sys, exp_st, (i >= 502));
                end
            end
        end
        vr = 1'b1;
        step(10);
        checks++;
        if (st !== 3'd5 || flt !== 1'b1) begin
            errors++;
            $display("FAIL late_vr: got st=%0d flt=%b want st=5 flt=1", st, flt);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (flt !== (i < 2) || st !== ((i < 2) ? 3'd5 : 3'd0)) begin
                errors++;
                $display("FAIL fault_clear k+%0d: got st=%0d flt=%b want flt=%b", i, st, flt, (i < 2));
            end
        end
    endtask

    task automatic test_vr_glitch();
        go_idle();
        en = 1'b1;
        vr = 1'b1;
        step(20);
        checks++;
        if (st !== 3'd4 || pch !== 1'b1 || sys !== 1'b1) begin
            errors++;
            $display("FAIL reach_on: got st=%0d pch=%b sys=%b want st=4 pch=1 sys=1", st, pch, sys);
        end
`ifdef PWROK_DEGLITCH_EN
        for (int w = 1; w < 3; w++) begin
            vr = 1'b0;
            step(w);
            vr = 1'b1;
            step(6);
            checks++;
            if (st !== 3'd4 || pch !== 1'b1 || sys !== 1'b1) begin
                errors++;
                $display("FAIL glitch_%0d: got st=%0d pch=%b sys=%b want st=4 pch=1 sys=1", w, st, pch, sys);
            end
        end
        vr = 1'b0;
        step(3);
        vr = 1'b1;
        step(1);
        checks++;
        if (st !== 3'd4 || pch !== 1'b1) begin
            errors++;
            $display("FAIL low3_hold: got st=%0d pch=%b want st=4 pch=1", st, pch);
        end
        step(1);
        checks++;
        if (st !== 3'd0 || pch !== 1'b0 || sys !== 1'b0) begin
            errors++;
            $display("FAIL low3_drop: got st=%0d pch=%b sys=%b want st=0 pch=0 sys=0", st, pch, sys);
        end
`else
        vr = 1'b0;
        step(1);
        vr = 1'b1;
        step(1);
        checks++;
        if (st !== 3'd4 || pch !== 1'b1 || sys !== 1'b1) begin
            errors++;
            $display("FAIL glitch_hold: got st=%0d pch=%b sys=%b want st=4 pch=1 sys=1", st, pch, sys);
        end
        step(1);
        checks++;
        if (st !== 3'd0 || pch !== 1'b0 || sys !== 1'b0) begin
            errors++;
            $display("FAIL glitch_drop: got st=%0d pch=%b sys=%b want st=0 pch=0 sys=0", st, pch, sys);
        end
`endif
    endtask

    task automatic test_dly_pch_drop();
        go_idle();
        en = 1'b1;
        vr = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step(1);
            checks++;
            if (pch !== 1'b0) begin
                errors++;
                $display("FAIL drop_pch k+%0d: got pch=%b want 0", i, pch);
            end
            if (i == 8) begin
                checks++;
                if (st !== 3'd2) begin
                    errors++;
                    $display("FAIL drop_cnt5: got st=%0d want 2", st);
                end
            end
            if (i == 12) begin
                checks++;
                if (st !== 3'd1) begin
                    errors++;
                    $display("FAIL drop_wait: got st=%0d want 1", st);
                end
            end
            if (i == 6) vr = 1'b0;
        end
        vr = 1'b1;
        for (int j = 0; j < 13; j++) begin
            step(1);
            if (j == 11 || j == 12) begin
                checks++;
                if (st !== ((j == 11) ? 3'd2 : 3'd3) || pch !== (j == 12)) begin
                    errors++;
                    $display("FAIL restart k+%0d: got st=%0d pch=%b want st=%0d pch=%b",
                             j, st, pch, ((j == 11) ? 3'd2 : 3'd3), (j == 12));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        en = 1'b1;
        vr = 1'b1;
        step(20);
        reset = 1'b1;
        step(1);
        checks++;
        if ({st, pch, sys, flt} !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid: got st=%0d pch=%b sys=%b flt=%b want all 0", st, pch, sys, flt);
        end
        reset = 1'b0;
        check_seq("reset_rerun");
    endtask

    task automatic test_min_delays();
        en2 = 1'b0;
        vr2 = 1'b0;
        step(4);
        en2 = 1'b1;
        vr2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            checks++;
            if (pch2 !== (i >= 4) || sys2 !== (i >= 5)) begin
                errors++;
                $display("FAIL min_seq k+%0d: got pch=%b sys=%b want pch=%b sys=%b",
                         i, pch2, sys2, (i >= 4), (i >= 5));
            end
        end
        en2 = 1'b0;
        step(4);
        vr2 = 1'b0;
        en2 = 1'b1;
        step(3);
        checks++;
        if (st2 !== 3'd1) begin
            errors++;
            $display("FAIL min_wait: got st=%0d want 1", st2);
        end
        step(1);
        checks++;
        if (st2 !== 3'd5 || flt2 !== 1'b1) begin
            errors++;
            $display("FAIL min_fault: got st=%0d flt=%b want st=5 flt=1", st2, flt2);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_vr_glitch();
        test_dly_pch_drop();
        test_reset_mid();
        test_min_delays();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
